// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider and the HI/LO result bus.
package div_unit_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Result-ready strobe levels.
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Start request levels driven by EX.
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  // Width alias for the {HI, LO} double register bus.
  localparam int unsigned RegBusW       = 32;
  localparam int unsigned DoubleRegBusW = 2 * RegBusW;
  typedef logic [DoubleRegBusW-1:0] double_reg_bus_t;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU. Produces {remainder, quotient}
// one bit per cycle; signed mode divides magnitudes and fixes signs at the end.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam int unsigned CntW = $clog2(DW) + 1;

  div_state_e      state;
  logic [CntW-1:0] cnt;
  logic [DW-1:0]   dvsr;      // divisor magnitude
  logic [DW-1:0]   rem;       // partial remainder
  logic [DW-1:0]   quo;       // dividend bits shift out as quotient bits shift in
  logic            neg_quot;
  logic            neg_rem;

  logic [DW-1:0] op1_abs;
  logic [DW-1:0] op2_abs;
  logic [DW:0]   partial;
  logic [DW:0]   diff;
  logic          step_ok;
  logic [DW-1:0] rem_step;
  logic [DW-1:0] quo_step;
  logic [DW-1:0] rem_fix;
  logic [DW-1:0] quo_fix;
  logic          last_step;

  // Operand magnitudes and one restoring-division step, plus final sign fix-up.
  always_comb begin
    op1_abs   = (signed_div_i && opdata1_i[DW-1]) ? (~opdata1_i + DW'(1)) : opdata1_i;
    op2_abs   = (signed_div_i && opdata2_i[DW-1]) ? (~opdata2_i + DW'(1)) : opdata2_i;
    partial   = {rem, quo[DW-1]};
    diff      = partial - {1'b0, dvsr};
    // A set top bit means the trial subtraction borrowed: restore.
    step_ok   = ~diff[DW];
    rem_step  = step_ok ? diff[DW-1:0] : partial[DW-1:0];
    quo_step  = {quo[DW-2:0], step_ok};
    quo_fix   = neg_quot ? (~quo_step + DW'(1)) : quo_step;
    rem_fix   = neg_rem ? (~rem_step + DW'(1)) : rem_step;
    last_step = (cnt == CntW'(DW - 1));
  end

  // Control FSM and datapath registers; result/ready are registered in END.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      dvsr     <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      unique case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state    <= DivOn;
              cnt      <= '0;
              dvsr     <= op2_abs;
              quo      <= op1_abs;
              rem      <= '0;
              neg_quot <= signed_div_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
              neg_rem  <= signed_div_i & opdata1_i[DW-1];
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            state <= DivEnd;
            rem   <= '0;
            quo   <= '0;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            cnt <= cnt + CntW'(1);
            if (last_step) begin
              rem   <= rem_fix;
              quo   <= quo_fix;
              state <= DivEnd;
            end else begin
              rem <= rem_step;
              quo <= quo_step;
            end
          end
        end
        DivEnd: begin
          if (start_i == DivStart && !annul_i) begin
            result_o <= {rem, quo};
            ready_o  <= DivResultReady;
          end else begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results and
// latencies, a negedge monitor checks them when ready_o rises.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  div_unit #(.DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   mon_en = 0;
  logic ready_prev = 1'b0;
  int   ready_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on the rising edge of ready, and require a zero bus otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ready) ready_seen++;
      if (ready && !ready_prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ready", {63'd0, ready}, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
        end
      end
      if (!ready) chk("idle_zero", result, 64'd0);
    end
    ready_prev = ready;
  end

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input bit scramble);
    int n;
    @(posedge clk); #1;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    acc_cyc    = cyc + 1;
    sb_q.push_back('{res: exp, lat: lat});
    @(posedge clk); #1;
    if (scramble) begin
      op1        = ~a;
      op2        = b + 32'd5;
      signed_div = ~sgn;
    end
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_within_bound", {63'd0, ready}, 64'd1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("drop_ready", {63'd0, ready}, 64'd0);
    chk("drop_result", result, 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    mon_en = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 1'b0);
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 33, 1'b0);
    run_div(1'b0, 32'hFFFFFFF9, 32'h2, {32'h1, 32'h7FFFFFFC}, 33, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 64'd0, 2, 1'b0);

    // Annulled division must never raise ready.
    @(posedge clk); #1;
    signed_div = 1'b0;
    op1        = 32'd100;
    op2        = 32'd7;
    start      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    start = 1'b0;
    ready_seen = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("annul_no_ready", 64'(ready_seen), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33, 1'b0);

    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 33, 1'b0);

    // Reset in the middle of a division.
    @(posedge clk); #1;
    op1   = 32'd100;
    op2   = 32'd7;
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_ready", {63'd0, ready}, 64'd0);
    chk("midreset_result", result, 64'd0);
    ready_seen = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("midreset_no_ready", 64'(ready_seen), 64'd0);

    // Fresh request; operands scrambled after acceptance.
    run_div(1'b0, 32'd1000, 32'd33, {32'hA, 32'h1E}, 33, 1'b1);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU.
- EX is the initiator: it raises a start request with operands and holds it. div_unit responds with a 64-bit {remainder, quotient} and a ready strobe, which EX forwards to HI/LO.
- EX asserts a pipeline stall request while it waits. The annul input lets the pipeline cancel an in-flight division, for example on a flush.

Parameters:
- DW, 32, operand width. The result width is 2*DW. The iteration counter is clog2(DW)+1 bits wide.

Ports:
- clk  in  1  clock. Reset rst is synchronous, active-high; clock is clk.
- rst  in  1  synchronous active-high reset.
- signed_div_i  in  1  1 selects signed DIV, 0 selects unsigned DIVU.
- opdata1_i  in  DW  dividend.
- opdata2_i  in  DW  divisor.
- start_i  in  1  division request. EX holds it high until it sees ready_o.
- annul_i  in  1  cancel request. It overrides start_i.
- result_o  out  2*DW  {remainder[DW-1:0], quotient[DW-1:0]}. Valid only while ready_o=1, otherwise 0.
- ready_o  out  1  result valid.

Behaviour:
- States: FREE, BYZERO, ON, END. State and all datapath registers are clocked on the rising edge of clk.
- Reset: state=FREE, cnt=0, result_o=0, ready_o=0. Reset wins in any state, including mid-division.
- FREE:
  - If start_i=1 and annul_i=0, operands are latched at this edge.
  - If opdata2_i==0, go to BYZERO.
  - Otherwise go to ON with cnt=0.
  - Signed mode: the absolute values of both operands are latched, and the operand sign bits are recorded.
  - Operand changes after acceptance are ignored.
- ON:
  - Performs one restoring-division step per edge. Trial-subtract the divisor from the partial remainder, shift in the next dividend bit, and shift the quotient bit in (1 on non-negative difference).
  - cnt increments on each step. After DW steps, state goes to END.
  - In that same edge: signed mode negates the quotient if the operand signs differ, and the remainder takes the dividend's sign.
  - If annul_i=1 at any edge in ON, go to FREE and produce no result.
- BYZERO: the next edge goes to END with result {0, 0}. An annul_i=1 at that edge goes to FREE instead.
- END:
  - ready_o=1 and result_o holds the result.
  - Stay in END while start_i=1 and annul_i=0.
  - Go to FREE on start_i=0 or annul_i=1. ready_o and result_o drop to 0 in the cycle after.
- Latency: ready_o rises DW+1 cycles (33) after the accepting edge for a nonzero divisor, and 2 cycles after for divide by zero.
- Back-to-back: a new request is accepted only from FREE, so EX must drop start_i for at least one cycle between divisions.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (two's-complement wrap, no trap).
- Unsigned mode uses the operands as is; no negation is applied.
- Any start_i=1 arriving while in ON or BYZERO is ignored.

Decomposition:
- defines.v receives:
  - the state encodings DivFree/DivByZero/DivOn/DivEnd (2-bit);
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop;
  - the DoubleRegBus width alias already used for HI/LO.
- No sub-module is required. The trial-subtract step is an inline DW+1-bit subtraction.

Test Plan:
- Unsigned 100/7 (signed_div_i=0, start held) -> ready_o rises exactly 33 cycles after acceptance, result_o={32'h2, 32'hE}. After start_i drops, ready_o=0 and result_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9, 0x2) -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}. Signed 7/-2 -> {32'h1, 32'hFFFFFFFD}.
- Divide by zero, 5/0 -> ready_o 2 cycles after acceptance, result_o={0, 0}.
- Annul: start 100/7, pulse annul_i at cycle 10 -> state FREE, ready_o never rises. A following 9/3 request returns {0, 3} after 33 cycles.
- Signed 0x80000000/0xFFFFFFFF -> {32'h0, 32'h80000000}. Unsigned 0xFFFFFFFF/1 -> {0, 32'hFFFFFFFF}.
- rst asserted at cycle 20 of a division -> next cycle ready_o=0, result_o=0. A fresh request then completes normally. Operands changed after acceptance do not alter the result.
